// File: rtl/tmds_encoder.sv
// TMDS 8b/10b channel encoder: a transition-minimising stage followed by a
// DC-balancing stage that tracks the running disparity of the channel.
module tmds_encoder #(
   parameter int REG_INPUT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        data,
   input  logic              c0,
   input  logic              c1,
   input  logic              blank,
   output logic [9:0]        symbol,
   output logic signed [4:0] disparity
);

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'd0, v[i]};
      end
      return n;
   endfunction

   function automatic logic [8:0] minimise(input logic [7:0] d);
      logic [3:0] n1;
      logic       use_xnor;
      logic [8:0] q;
      n1       = popcount8(d);
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && (d[0] == 1'b0));
      q        = 9'd0;
      q[0]     = d[0];
      for (int i = 1; i < 8; i++) begin
         if (use_xnor) begin
            q[i] = ~(q[i-1] ^ d[i]);
         end else begin
            q[i] = q[i-1] ^ d[i];
         end
      end
      q[8] = ~use_xnor;
      return q;
   endfunction

   logic [8:0]        w_qm_in;
   logic [3:0]        w_n1q_in;
   logic [3:0]        w_n0q_in;
   logic [8:0]        w_qm;
   logic [3:0]        w_n1q;
   logic [3:0]        w_n0q;
   logic              w_blank;
   logic              w_c0;
   logic              w_c1;
   logic [9:0]        w_sym_nxt;
   logic signed [5:0] w_cnt_nxt;
   logic signed [5:0] w_cnt_ext;
   logic signed [5:0] w_diff;
   logic [9:0]        r_symbol;
   logic signed [4:0] r_cnt;

   assign w_qm_in  = minimise(data);
   assign w_n1q_in = popcount8(w_qm_in[7:0]);
   assign w_n0q_in = 4'd8 - w_n1q_in;

   generate
      if (REG_INPUT != 0) begin : g_reg
         logic [8:0] r_qm;
         logic [3:0] r_n1q;
         logic [3:0] r_n0q;
         logic       r_blank;
         logic       r_c0;
         logic       r_c1;

         // Blank resets high so the pipeline drains control code 00 after reset.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_qm    <= 9'd0;
               r_n1q   <= 4'd0;
               r_n0q   <= 4'd0;
               r_blank <= 1'b1;
               r_c0    <= 1'b0;
               r_c1    <= 1'b0;
            end else begin
               r_qm    <= w_qm_in;
               r_n1q   <= w_n1q_in;
               r_n0q   <= w_n0q_in;
               r_blank <= blank;
               r_c0    <= c0;
               r_c1    <= c1;
            end
         end

         assign w_qm    = r_qm;
         assign w_n1q   = r_n1q;
         assign w_n0q   = r_n0q;
         assign w_blank = r_blank;
         assign w_c0    = r_c0;
         assign w_c1    = r_c1;
      end else begin : g_comb
         assign w_qm    = w_qm_in;
         assign w_n1q   = w_n1q_in;
         assign w_n0q   = w_n0q_in;
         assign w_blank = blank;
         assign w_c0    = c0;
         assign w_c1    = c1;
      end
   endgenerate

   assign w_cnt_ext = {r_cnt[4], r_cnt};
   assign w_diff    = $signed({2'b00, w_n1q}) - $signed({2'b00, w_n0q});

   // Choose inversion so the running disparity is pulled back towards zero.
   always_comb begin
      w_sym_nxt = 10'b1101010100;
      w_cnt_nxt = 6'sd0;
      if (w_blank) begin
         case ({w_c1, w_c0})
            2'b00:   w_sym_nxt = 10'b1101010100;
            2'b01:   w_sym_nxt = 10'b0010101011;
            2'b10:   w_sym_nxt = 10'b0101010100;
            2'b11:   w_sym_nxt = 10'b1010101011;
            default: w_sym_nxt = 10'b1101010100;
         endcase
         w_cnt_nxt = 6'sd0;
      end else if ((r_cnt == 5'sd0) || (w_n1q == w_n0q)) begin
         w_sym_nxt = {~w_qm[8], w_qm[8], (w_qm[8] ? w_qm[7:0] : ~w_qm[7:0])};
         w_cnt_nxt = w_cnt_ext + (w_qm[8] ? w_diff : -w_diff);
      end else if (((r_cnt > 5'sd0) && (w_n1q > w_n0q)) ||
                   ((r_cnt < 5'sd0) && (w_n0q > w_n1q))) begin
         w_sym_nxt = {1'b1, w_qm[8], ~w_qm[7:0]};
         w_cnt_nxt = w_cnt_ext + (w_qm[8] ? 6'sd2 : 6'sd0) - w_diff;
      end else begin
         w_sym_nxt = {1'b0, w_qm[8], w_qm[7:0]};
         w_cnt_nxt = w_cnt_ext + w_diff - (w_qm[8] ? 6'sd0 : 6'sd2);
      end
   end

   // Output symbol and running disparity register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_symbol <= 10'b1101010100;
         r_cnt    <= 5'sd0;
      end else begin
         r_symbol <= w_sym_nxt;
         r_cnt    <= w_cnt_nxt[4:0];
      end
   end

   assign symbol    = r_symbol;
   assign disparity = r_cnt;

endmodule

// File: tb/tb_tmds_encoder.sv
// Directed and randomised checks of tmds_encoder, with both the registered
// (2-clk) and combinational-input (1-clk) builds driven from the same inputs.
module tb_tmds_encoder;

   logic              clk;
   logic              reset;
   logic [7:0]        data;
   logic              c0;
   logic              c1;
   logic              blank;
   logic [9:0]        sym1;
   logic signed [4:0] disp1;
   logic [9:0]        sym0;
   logic signed [4:0] disp0;

   int checks;
   int errors;
   int m_cnt;

   localparam logic [9:0] CTL [4] = '{10'b1101010100, 10'b0010101011,
                                      10'b0101010100, 10'b1010101011};
   localparam logic [9:0] ZSYM [3] = '{10'b0100000000, 10'b1111111111,
                                       10'b0100000000};
   localparam int         ZDISP [3] = '{-8, 2, -6};
   localparam int         NRAND = 2000;

   logic [9:0] exp_sym [NRAND];
   int         exp_cnt [NRAND];
   logic       exp_blk [NRAND];

   tmds_encoder #(.REG_INPUT(1)) u_dut1 (
      .clk(clk), .reset(reset), .data(data), .c0(c0), .c1(c1),
      .blank(blank), .symbol(sym1), .disparity(disp1));

   tmds_encoder #(.REG_INPUT(0)) u_dut0 (
      .clk(clk), .reset(reset), .data(data), .c0(c0), .c1(c1),
      .blank(blank), .symbol(sym0), .disparity(disp0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one input set on the falling edge, then sample just after the rising edge.
   task automatic step(input logic [7:0] d, input logic b, input logic k1, input logic k0);
      @(negedge clk);
      data  = d;
      blank = b;
      c1    = k1;
      c0    = k0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      data  = 8'h00;
      blank = 1'b1;
      c0    = 1'b0;
      c1    = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      m_cnt = 0;
   endtask

   // Independent reference: written straight from the encoding rules, integer arithmetic.
   task automatic model_step(input logic [7:0] d, input logic b, input logic k1,
                             input logic k0, output logic [9:0] s);
      int   n1, ones, zeros;
      logic xn;
      logic [8:0] q;
      if (b) begin
         s     = CTL[{k1, k0}];
         m_cnt = 0;
      end else begin
         n1   = $countones(d);
         xn   = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
         q[0] = d[0];
         for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
         q[8]  = ~xn;
         ones  = $countones(q[7:0]);
         zeros = 8 - ones;
         if (m_cnt == 0 || ones == zeros) begin
            s     = q[8] ? {2'b01, q[7:0]} : {2'b10, ~q[7:0]};
            m_cnt = m_cnt + (q[8] ? ones - zeros : zeros - ones);
         end else if ((m_cnt > 0 && ones > zeros) || (m_cnt < 0 && zeros > ones)) begin
            s     = {1'b1, q[8], ~q[7:0]};
            m_cnt = m_cnt + (q[8] ? 2 : 0) + zeros - ones;
         end else begin
            s     = {1'b0, q[8], q[7:0]};
            m_cnt = m_cnt + ones - zeros - (q[8] ? 0 : 2);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (sym1 !== 10'b1101010100 || disp1 !== 5'sd0) begin
         errors++;
         $display("FAIL reset_init: got sym=%b disp=%0d want 1101010100/0", sym1, disp1);
      end
      for (int j = 0; j < 3; j++) step(8'h00, 1'b0, 1'b0, 1'b0);
      checks++;
      if (int'(disp1) !== 2) begin
         errors++;
         $display("FAIL reset_pre: got disp=%0d want 2", disp1);
      end
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (sym1 !== 10'b1101010100 || disp1 !== 5'sd0 || sym0 !== 10'b1101010100 || disp0 !== 5'sd0) begin
         errors++;
         $display("FAIL reset_async: got sym1=%b disp1=%0d sym0=%b disp0=%0d want 1101010100/0",
                  sym1, disp1, sym0, disp0);
      end
      @(negedge clk);
      reset = 1'b0;
      data  = 8'hFF;
      blank = 1'b0;
      c0    = 1'b0;
      c1    = 1'b0;
      m_cnt = 0;
      @(posedge clk);
      #1;
      checks++;
      if (sym1 !== 10'b1101010100 || disp1 !== 5'sd0) begin
         errors++;
         $display("FAIL reset_drain1: got sym=%b disp=%0d want 1101010100/0", sym1, disp1);
      end
      checks++;
      if (sym0 !== 10'b1000000000 || int'(disp0) !== -8) begin
         errors++;
         $display("FAIL reset_first0: got sym=%b disp=%0d want 1000000000/-8", sym0, disp0);
      end
      step(8'h00, 1'b1, 1'b0, 1'b0);
      checks++;
      if (sym1 !== 10'b1000000000 || int'(disp1) !== -8) begin
         errors++;
         $display("FAIL reset_first1: got sym=%b disp=%0d want 1000000000/-8", sym1, disp1);
      end
   endtask

   task automatic test_control();
      do_reset();
      for (int j = 0; j < 5; j++) begin
         if (j < 4) step(8'hA5, 1'b1, j[1], j[0]);
         else       step(8'h00, 1'b1, 1'b0, 1'b0);
         if (j >= 1) begin
            checks++;
            if (sym1 !== CTL[j-1] || disp1 !== 5'sd0) begin
               errors++;
               $display("FAIL control_%0d: got sym=%b disp=%0d want %b/0", j-1, sym1, disp1, CTL[j-1]);
            end
         end
      end
   endtask

   task automatic test_zero_stream();
      do_reset();
      for (int j = 0; j < 4; j++) begin
         if (j < 3) step(8'h00, 1'b0, 1'b0, 1'b0);
         else       step(8'h00, 1'b1, 1'b0, 1'b0);
         if (j >= 1) begin
            checks++;
            if (sym1 !== ZSYM[j-1] || int'(disp1) !== ZDISP[j-1]) begin
               errors++;
               $display("FAIL zero_reg_%0d: got sym=%b disp=%0d want %b/%0d",
                        j-1, sym1, disp1, ZSYM[j-1], ZDISP[j-1]);
            end
         end
         if (j < 3) begin
            checks++;
            if (sym0 !== ZSYM[j] || int'(disp0) !== ZDISP[j]) begin
               errors++;
               $display("FAIL zero_comb_%0d: got sym=%b disp=%0d want %b/%0d",
                        j, sym0, disp0, ZSYM[j], ZDISP[j]);
            end
         end
      end
   endtask

   task automatic test_full_byte();
      do_reset();
      step(8'hFF, 1'b0, 1'b0, 1'b0);
      step(8'h00, 1'b1, 1'b0, 1'b0);
      checks++;
      if (sym1 !== 10'b1000000000 || int'(disp1) !== -8) begin
         errors++;
         $display("FAIL full_byte: got sym=%b disp=%0d want 1000000000/-8", sym1, disp1);
      end
      step(8'h00, 1'b1, 1'b0, 1'b0);
      checks++;
      if (sym1 !== 10'b1101010100 || disp1 !== 5'sd0) begin
         errors++;
         $display("FAIL full_blank: got sym=%b disp=%0d want 1101010100/0", sym1, disp1);
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] bsym [4];
      int         bdisp [4];
      bsym  = '{10'b0010101011, 10'b0100000000, 10'b0101010100, 10'b1000000000};
      bdisp = '{0, -8, 0, -8};
      do_reset();
      for (int j = 0; j < 5; j++) begin
         case (j)
            0:       step(8'h33, 1'b1, 1'b0, 1'b1);
            1:       step(8'h00, 1'b0, 1'b0, 1'b0);
            2:       step(8'h33, 1'b1, 1'b1, 1'b0);
            3:       step(8'hFF, 1'b0, 1'b0, 1'b0);
            default: step(8'h00, 1'b1, 1'b0, 1'b0);
         endcase
         if (j >= 1) begin
            checks++;
            if (sym1 !== bsym[j-1] || int'(disp1) !== bdisp[j-1]) begin
               errors++;
               $display("FAIL b2b_%0d: got sym=%b disp=%0d want %b/%0d",
                        j-1, sym1, disp1, bsym[j-1], bdisp[j-1]);
            end
         end
      end
   endtask

   task automatic test_random();
      int         burst;
      int         run_bal;
      logic [7:0] d;
      logic       b, k1, k0;
      logic [9:0] s;
      burst   = 0;
      run_bal = 0;
      do_reset();
      for (int j = 0; j <= NRAND; j++) begin
         if (j < NRAND) begin
            d  = 8'($urandom_range(0, 255));
            k1 = 1'($urandom_range(0, 1));
            k0 = 1'($urandom_range(0, 1));
            if (burst == 0 && $urandom_range(0, 15) == 0) burst = int'($urandom_range(1, 4));
            b = (burst > 0);
            if (burst > 0) burst--;
            model_step(d, b, k1, k0, s);
            exp_sym[j] = s;
            exp_cnt[j] = m_cnt;
            exp_blk[j] = b;
            step(d, b, k1, k0);
            checks++;
            if (sym0 !== exp_sym[j] || int'(disp0) !== exp_cnt[j]) begin
               errors++;
               $display("FAIL rand_comb_%0d: got sym=%b disp=%0d want %b/%0d",
                        j, sym0, disp0, exp_sym[j], exp_cnt[j]);
            end
         end else begin
            step(8'h00, 1'b1, 1'b0, 1'b0);
         end
         if (j >= 1) begin
            checks++;
            if (sym1 !== exp_sym[j-1] || int'(disp1) !== exp_cnt[j-1]) begin
               errors++;
               $display("FAIL rand_reg_%0d: got sym=%b disp=%0d want %b/%0d",
                        j-1, sym1, disp1, exp_sym[j-1], exp_cnt[j-1]);
            end
            if (exp_blk[j-1]) run_bal = 0;
            else              run_bal = run_bal + 2 * $countones(sym1) - 10;
            checks++;
            if (int'(disp1) !== run_bal) begin
               errors++;
               $display("FAIL rand_balance_%0d: got disp=%0d want %0d", j-1, disp1, run_bal);
            end
            checks++;
            if (disp1[0] !== 1'b0 || int'(disp1) < -16 || int'(disp1) > 15) begin
               errors++;
               $display("FAIL rand_even_%0d: got disp=%0d want even in [-16,15]", j-1, disp1);
            end
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_cnt  = 0;
      reset  = 1'b1;
      data   = 8'h00;
      blank  = 1'b1;
      c0     = 1'b0;
      c1     = 1'b0;
      test_reset();
      test_control();
      test_zero_stream();
      test_full_byte();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
